// File: rtl/xprog_loader_pkg.sv
// Shared widths, FSM state encoding and status codes for the program loader.
package xprog_loader_pkg;

  localparam int unsigned PROG_RAM_ADDR_W = 8;
  localparam int unsigned DATA_W          = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RECV  = 3'd1,
    ST_WRITE = 3'd2,
    ST_CSUM  = 3'd3,
    ST_FIN   = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    ERR_OK      = 2'd0,
    ERR_CSUM    = 2'd1,
    ERR_TIMEOUT = 2'd2
  } err_e;

endpackage

// File: rtl/xprog_loader_asm.sv
// Byte-lane assembler: little-endian word build, lane index and running 8-bit checksum.
module xprog_loader_asm
  import xprog_loader_pkg::*;
#(
  parameter int unsigned BPW = DATA_W / 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr_i,
  input  logic               xfer_i,
  input  logic [7:0]         byte_i,
  output logic               last_c,
  output logic [8*BPW-1:0]   word_c,
  output logic [7:0]         csum_c
);

  localparam int unsigned IW = (BPW > 1) ? $clog2(BPW) : 1;

  logic [IW-1:0]      idx_q;
  logic [8*BPW-1:0]   word_q;
  logic [7:0]         csum_q;

  // Word as it will look once the byte currently on the bus lands in its lane.
  always_comb begin
    word_c = word_q;
    for (int unsigned i = 0; i < BPW; i++) begin
      if (idx_q == IW'(i)) word_c[8*i +: 8] = byte_i;
    end
  end

  assign last_c = (idx_q == IW'(BPW - 1));
  assign csum_c = csum_q + byte_i;

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      idx_q  <= '0;
      word_q <= '0;
      csum_q <= '0;
    end else if (xfer_i) begin
      word_q <= word_c;
      csum_q <= csum_c;
      idx_q  <= last_c ? '0 : idx_q + IW'(1);
    end
  end

endmodule

// File: rtl/xprog_loader.sv
// Streams bytes from a receiver into program RAM, one word per BPW bytes, then verifies a checksum byte.
module xprog_loader
  import xprog_loader_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1000000,
  parameter int unsigned BPW     = DATA_W / 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [PROG_RAM_ADDR_W-1:0] base,
  input  logic [PROG_RAM_ADDR_W-1:0] len,
  input  logic [7:0]                 rx_data,
  input  logic                       rx_valid,
  output logic                       rx_ready,
  output logic                       data_sel,
  output logic                       data_we,
  output logic [PROG_RAM_ADDR_W-1:0] data_addr,
  output logic [8*BPW-1:0]           data_in,
  output logic                       busy,
  output logic                       done,
  output logic [1:0]                 err
);

  localparam int unsigned AW = PROG_RAM_ADDR_W;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  state_e             state_q, state_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic [AW-1:0]      words_q, words_d;
  logic [TW-1:0]      timer_q, timer_d;
  err_e               err_q, err_d;
  logic               rx_ready_q, busy_q, done_q, we_q;
  logic [AW-1:0]      data_addr_q;
  logic [8*BPW-1:0]   data_in_q;

  logic               xfer_c, asm_clr_c, last_c;
  logic [8*BPW-1:0]   word_c;
  logic [7:0]         csum_c;

  assign xfer_c = rx_valid & rx_ready_q;

  xprog_loader_asm #(.BPW(BPW)) u_asm (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (asm_clr_c),
    .xfer_i (xfer_c),
    .byte_i (rx_data),
    .last_c (last_c),
    .word_c (word_c),
    .csum_c (csum_c)
  );

  // Next-state logic; the idle timer only advances while waiting on a byte.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    words_d   = words_q;
    timer_d   = timer_q;
    err_d     = err_q;
    asm_clr_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d    = base;
          words_d   = len;
          timer_d   = '0;
          err_d     = ERR_OK;
          asm_clr_c = 1'b1;
          state_d   = (len == '0) ? ST_CSUM : ST_RECV;
        end
      end
      ST_RECV: begin
        if (xfer_c) begin
          timer_d = '0;
          if (last_c) state_d = ST_WRITE;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          err_d   = ERR_TIMEOUT;
          state_d = ST_FIN;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_WRITE: begin
        addr_d  = addr_q + AW'(1);
        words_d = words_q - AW'(1);
        state_d = (words_q == AW'(1)) ? ST_CSUM : ST_RECV;
      end
      ST_CSUM: begin
        if (xfer_c) begin
          timer_d = '0;
          err_d   = (csum_c == 8'h00) ? ERR_OK : ERR_CSUM;
          state_d = ST_FIN;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          err_d   = ERR_TIMEOUT;
          state_d = ST_FIN;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      words_q     <= '0;
      timer_q     <= '0;
      err_q       <= ERR_OK;
      rx_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      we_q        <= 1'b0;
      data_addr_q <= '0;
      data_in_q   <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      words_q    <= words_d;
      timer_q    <= timer_d;
      err_q      <= err_d;
      rx_ready_q <= (state_d == ST_RECV) || (state_d == ST_CSUM);
      busy_q     <= (state_d != ST_IDLE);
      done_q     <= (state_d == ST_FIN);
      we_q       <= (state_d == ST_WRITE);
      if (state_d == ST_WRITE) begin
        data_addr_q <= addr_q;
        data_in_q   <= word_c;
      end
    end
  end

  assign rx_ready  = rx_ready_q;
  assign data_sel  = we_q;
  assign data_we   = we_q;
  assign data_addr = data_addr_q;
  assign data_in   = data_in_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule
